cv32e40x_fetch_sequencer: RTL
=============================

CV32E40X_FETCH_SEQUENCER -- requirements
Module: cv32e40x_fetch_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning maximum words reserved (outstanding plus buffered); legal range 2..4.
REQ-002 SHALL have parameter MAX_OUT, default 2, meaning maximum outstanding bus transactions; legal range 1..DEPTH.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 fetch_en_i  input  1  controller permits new fetch requests.
REQ-006 ctrl_pc_set_i / ctrl_pc_i[31:0] / ctrl_ptr_i / ctrl_priv_i(privlvl_t)  input  controller PC set (exception, interrupt, mret, pointer).
REQ-007 branch_set_i / branch_target_i[31:0]  input  taken branch from EX.
REQ-008 jump_set_i / jump_target_i[31:0]  input  jump from ID.
REQ-009 cur_priv_i  input  privlvl_t  current privilege level.
REQ-010 fetch_valid_o, fetch_branch_o, fetch_branch_addr_o[31:0], fetch_ptr_access_o, fetch_priv_lvl_access_o(privlvl_t)  output  request to prefetcher.
REQ-011 fetch_ready_i  input  1  prefetcher handshake accepted.
REQ-012 resp_valid_i  input  1  bus response this cycle.
REQ-013 buf_pop_i  input  1  one buffered word consumed by decode.
REQ-014 resp_discard_o  output  1  current response is stale; buffer drops it.
REQ-015 buf_flush_o  output  1  clear instruction buffer this cycle.
REQ-016 outstanding_o  output  $clog2(MAX_OUT+1)  outstanding transaction count.

Function
REQ-017 SHALL implement FSM states IDLE, RUN; reset to IDLE; IDLE->RUN on ctrl_pc_set_i; no other transition (RUN holds until reset).
REQ-018 SHALL select the PC source by fixed priority ctrl > branch > jump; fetch_branch_o = any set, combinational, same cycle, in either state.
REQ-019 SHALL drive fetch_ptr_access_o = ctrl_ptr_i and fetch_priv_lvl_access_o = ctrl_priv_i for a ctrl set; otherwise ptr = 0 and priv = cur_priv_i.
REQ-020 SHALL assert buf_flush_o combinationally whenever fetch_branch_o = 1.
REQ-021 SHALL maintain counters outstanding_q (0..MAX_OUT), buffered_q (0..DEPTH) and discard_q (0..MAX_OUT).
REQ-022 SHALL drive fetch_valid_o = RUN and fetch_en_i and outstanding_q < MAX_OUT and (outstanding_q + B) < DEPTH, where B = 0 in a branch cycle, else buffered_q; buf_pop_i is not forwarded into the credit check.
REQ-023 outstanding_q SHALL increment on fetch_valid_o and fetch_ready_i, decrement on resp_valid_i, both in the same cycle = unchanged.
REQ-024 resp_discard_o SHALL be resp_valid_i and (discard_q != 0 or fetch_branch_o).
REQ-025 buffered_q SHALL increment on resp_valid_i and not resp_discard_o, decrement on buf_pop_i, and load 0 (plus a non-discarded response: none) on flush.
REQ-026 On a branch cycle, discard_q SHALL load outstanding_q - resp_valid_i; the same-cycle issued request is never discarded.
REQ-027 Otherwise discard_q SHALL decrement on each resp_valid_i while nonzero.
REQ-028 Counter overflow/underflow is illegal stimulus; assertions SHALL flag resp_valid_i with outstanding_q = 0 and buf_pop_i with buffered_q = 0.
REQ-029 fetch_valid_o SHALL be permitted to drop without handshake (prefetcher replays the branch target internally).

Reset
REQ-030 During rst_n low: state IDLE, all counters 0; fetch_valid_o, resp_discard_o, outstanding_o = 0; the other outputs follow their inputs combinationally.
REQ-031 Reset mid-operation SHALL abandon all counts; responses after reset release are illegal stimulus.

Structure
REQ-032 typedef fetch_seq_state_e {IDLE, RUN} SHALL live in cv32e40x_pkg; privlvl_t is reused from there.
REQ-033 Single module, no sub-modules; counters are inline.

Verification
REQ-034 Boot: reset, fetch_en_i = 1, ctrl_pc_set_i with ctrl_pc_i = 0x0000_0080 -> fetch_branch_o = 1, addr 0x80, state RUN next cycle, fetch_valid_o = 1.
REQ-035 Credit limit (DEPTH = 2): two accepted requests, no responses -> fetch_valid_o = 0 and outstanding_o = 2 until resp_valid_i.
REQ-036 Branch with 2 outstanding, no response that cycle -> buf_flush_o = 1, discard_q = 2, next two responses have resp_discard_o = 1, third does not.
REQ-037 Simultaneous ctrl_pc_set_i (0x100), branch_set_i (0x200) and jump_set_i (0x300) -> addr 0x100, ptr = ctrl_ptr_i.
REQ-038 Branch coincident with resp_valid_i, outstanding_q = 1 -> that response discarded, discard_q = 0, new request issued same cycle.
REQ-039 Buffer full (buffered_q = 2), then buf_pop_i -> fetch_valid_o = 1 in the following cycle, not the pop cycle.

Source files
------------

// File: rtl/cv32e40x_pkg.sv
// Shared types for the cv32e40x fetch path.
// Privilege levels and fetch sequencer state encoding.
package cv32e40x_pkg;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_H = 2'b10,
        PRIV_LVL_M = 2'b11
    } privlvl_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_seq_state_e;

endpackage

// File: rtl/cv32e40x_fetch_sequencer.sv
// Fetch sequencer: PC source selection, request credit control
// and stale-response tracking for the instruction prefetcher.
module cv32e40x_fetch_sequencer
    import cv32e40x_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int MAX_OUT = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fetch_en_i,
    input  logic                         ctrl_pc_set_i,
    input  logic [31:0]                  ctrl_pc_i,
    input  logic                         ctrl_ptr_i,
    input  privlvl_t                     ctrl_priv_i,
    input  logic                         branch_set_i,
    input  logic [31:0]                  branch_target_i,
    input  logic                         jump_set_i,
    input  logic [31:0]                  jump_target_i,
    input  privlvl_t                     cur_priv_i,
    output logic                         fetch_valid_o,
    output logic                         fetch_branch_o,
    output logic [31:0]                  fetch_branch_addr_o,
    output logic                         fetch_ptr_access_o,
    output privlvl_t                     fetch_priv_lvl_access_o,
    input  logic                         fetch_ready_i,
    input  logic                         resp_valid_i,
    input  logic                         buf_pop_i,
    output logic                         resp_discard_o,
    output logic                         buf_flush_o,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding_o
);

    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int BW = $clog2(DEPTH + 1);
    localparam int CW = BW + 1;

    fetch_seq_state_e state_q, state_d;
    logic             run;

    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [BW-1:0] buffered_q, buffered_d;
    logic [OW-1:0] discard_q, discard_d;

    logic          issue;
    logic          resp_keep;
    logic [CW-1:0] credit_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ctrl_pc_set_i) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        run = (state_q == RUN);
    end

    // Controller redirects outrank EX branches, which outrank ID jumps
    always_comb begin
        fetch_branch_addr_o     = 32'h0;
        fetch_ptr_access_o      = 1'b0;
        fetch_priv_lvl_access_o = cur_priv_i;
        priority case (1'b1)
            ctrl_pc_set_i: begin
                fetch_branch_addr_o     = ctrl_pc_i;
                fetch_ptr_access_o      = ctrl_ptr_i;
                fetch_priv_lvl_access_o = ctrl_priv_i;
            end
            branch_set_i: fetch_branch_addr_o = branch_target_i;
            jump_set_i:   fetch_branch_addr_o = jump_target_i;
            default:      fetch_branch_addr_o = 32'h0;
        endcase
    end

    assign fetch_branch_o = ctrl_pc_set_i | branch_set_i | jump_set_i;
    assign buf_flush_o    = fetch_branch_o;

    // A redirect empties the buffer, so its words stop consuming credit
    assign credit_sum = CW'(outstanding_q)
                      + (fetch_branch_o ? '0 : CW'(buffered_q));

    assign fetch_valid_o = run && fetch_en_i
                        && (outstanding_q < OW'(MAX_OUT))
                        && (credit_sum < CW'(DEPTH));

    assign issue = fetch_valid_o & fetch_ready_i;

    assign resp_discard_o = rst_n & resp_valid_i
                          & ((discard_q != '0) | fetch_branch_o);

    assign resp_keep = resp_valid_i & ~resp_discard_o;

    assign outstanding_o = outstanding_q;

    always_comb begin
        outstanding_d = outstanding_q;
        unique case ({issue, resp_valid_i})
            2'b10:   outstanding_d = outstanding_q + OW'(1);
            2'b01:   outstanding_d = outstanding_q - OW'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_comb begin
        buffered_d = buffered_q;
        if (buf_flush_o) begin
            buffered_d = '0;
        end else begin
            unique case ({resp_keep, buf_pop_i})
                2'b10:   buffered_d = buffered_q + BW'(1);
                2'b01:   buffered_d = buffered_q - BW'(1);
                default: buffered_d = buffered_q;
            endcase
        end
    end

    // Everything in flight at a redirect is stale except this cycle's issue
    always_comb begin
        discard_d = discard_q;
        if (fetch_branch_o) begin
            discard_d = outstanding_q - OW'(resp_valid_i);
        end else if (resp_valid_i && (discard_q != '0)) begin
            discard_d = discard_q - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_q <= '0;
            buffered_q    <= '0;
            discard_q     <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            buffered_q    <= buffered_d;
            discard_q     <= discard_d;
        end
    end

    a_resp_underflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(resp_valid_i && (outstanding_q == '0))
    );

    a_pop_underflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(buf_pop_i && (buffered_q == '0))
    );

endmodule
